// File: rtl/crc_pkg.sv
// Shared types and constants for the CRC frame sequencer and its step datapath.
package crc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } crc_state_t;

   localparam logic MODE_GEN = 1'b0;
   localparam logic MODE_CHK = 1'b1;

endpackage

// File: rtl/crc_step.sv
// One combinational CRC step: folds a data word into the running remainder by
// GF(2) long division of ((data ^ crc_in aligned to the top) * x^(WPOLY-1)) by poly.
module crc_step #(
   parameter int WCODE = 9,
   parameter int WPOLY = 5
) (
   input  logic [WCODE-1:0] data,
   input  logic [WPOLY-1:0] poly,
   input  logic [WPOLY-2:0] crc_in,
   output logic [WPOLY-2:0] crc_out
);

   localparam int W  = WCODE + WPOLY - 1;
   localparam int SH = WCODE - WPOLY + 1;

   logic [WCODE-1:0] msg;
   logic [W-1:0]     poly_ext;
   logic [W-1:0]     stage [0:WCODE-1];

   assign msg      = data ^ (WCODE'(crc_in) << SH);
   assign poly_ext = W'(poly);
   assign stage[0] = {msg, {(WPOLY-1){1'b0}}};

   // Each stage clears one leading bit of the dividend, from the top down.
   generate
      for (genvar gi = 0; gi < WCODE - 1; gi++) begin : g_div
         assign stage[gi+1] = stage[gi][W-1-gi] ? (stage[gi] ^ (poly_ext << (WCODE-1-gi)))
                                                : stage[gi];
      end
   endgenerate

   assign crc_out = stage[WCODE-1][WPOLY-1] ? (stage[WCODE-1][WPOLY-2:0] ^ poly[WPOLY-2:0])
                                            : stage[WCODE-1][WPOLY-2:0];

endmodule

// File: rtl/crc_frame_ctrl.sv
// Frame sequencer: accepts i_len words over valid/ready, chains one CRC step per
// word and reports the final remainder (generate) or a mismatch flag (check).
module crc_frame_ctrl
   import crc_pkg::*;
#(
   parameter int WCODE = 9,
   parameter int WPOLY = 5,
   parameter int WLEN  = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic             i_mode,
   input  logic [WPOLY-1:0] i_poly,
   input  logic [WLEN-1:0]  i_len,
   input  logic [WPOLY-2:0] i_crc_exp,
   input  logic             i_abort,
   input  logic [WCODE-1:0] i_data,
   input  logic             i_valid,
   output logic             o_ready,
   output logic             o_busy,
   output logic             o_done,
   output logic [WPOLY-2:0] o_crc,
   output logic             o_err
);

   crc_state_t       state_q, state_d;
   logic [WLEN-1:0]  count_q, count_d;
   logic [WPOLY-2:0] crc_q, crc_d;
   logic [WPOLY-1:0] poly_q, poly_d;
   logic             mode_q, mode_d;
   logic [WPOLY-2:0] crc_exp_q, crc_exp_d;
   logic [WPOLY-2:0] crc_out_q, crc_out_d;
   logic             err_q, err_d;
   logic [WPOLY-2:0] step_out;

   crc_step #(
      .WCODE (WCODE),
      .WPOLY (WPOLY)
   ) u_step (
      .data    (i_data),
      .poly    (poly_q),
      .crc_in  (crc_q),
      .crc_out (step_out)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= IDLE;
         count_q   <= '0;
         crc_q     <= '0;
         poly_q    <= '0;
         mode_q    <= MODE_GEN;
         crc_exp_q <= '0;
         crc_out_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         crc_q     <= crc_d;
         poly_q    <= poly_d;
         mode_q    <= mode_d;
         crc_exp_q <= crc_exp_d;
         crc_out_q <= crc_out_d;
         err_q     <= err_d;
      end
   end

   // The reported result is captured on entry to DONE so it is visible during the pulse.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      crc_d     = crc_q;
      poly_d    = poly_q;
      mode_d    = mode_q;
      crc_exp_d = crc_exp_q;
      crc_out_d = crc_out_q;
      err_d     = err_q;
      o_ready   = 1'b0;
      o_busy    = 1'b0;
      o_done    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (i_start) begin
               poly_d    = i_poly;
               mode_d    = i_mode;
               crc_exp_d = i_crc_exp;
               crc_d     = '0;
               count_d   = i_len;
               if (i_len == '0) begin
                  state_d   = DONE;
                  crc_out_d = '0;
                  err_d     = (i_mode == MODE_CHK) && (i_crc_exp != '0);
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            o_busy  = 1'b1;
            o_ready = !i_abort;
            if (i_abort) begin
               state_d = IDLE;
            end else if (i_valid) begin
               crc_d   = step_out;
               count_d = count_q - 1'b1;
               if (count_q == WLEN'(1)) begin
                  state_d   = DONE;
                  crc_out_d = step_out;
                  err_d     = (mode_q == MODE_CHK) && (step_out != crc_exp_q);
               end
            end
         end
         DONE: begin
            o_done  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign o_crc = crc_out_q;
   assign o_err = err_q;

endmodule

// File: tb/tb_crc_frame_ctrl.sv
// Directed bench for crc_frame_ctrl with a whole-message CRC reference model.
module tb_crc_frame_ctrl;

   localparam int WCODE = 9;
   localparam int WPOLY = 5;
   localparam int WLEN  = 8;
   localparam logic [4:0] POLY = 5'b10011;

   logic       clk = 1'b0;
   logic       i_rst = 1'b1;
   logic       i_start = 1'b0;
   logic       i_mode = 1'b0;
   logic [4:0] i_poly = POLY;
   logic [7:0] i_len = '0;
   logic [3:0] i_crc_exp = '0;
   logic       i_abort = 1'b0;
   logic [8:0] i_data = '0;
   logic       i_valid = 1'b0;
   logic       o_ready, o_busy, o_done, o_err;
   logic [3:0] o_crc;

   int checks = 0;
   int errors = 0;
   int done_seen = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   crc_frame_ctrl #(
      .WCODE (WCODE),
      .WPOLY (WPOLY),
      .WLEN  (WLEN)
   ) dut (
      .i_clk     (clk),
      .i_rst     (i_rst),
      .i_start   (i_start),
      .i_mode    (i_mode),
      .i_poly    (i_poly),
      .i_len     (i_len),
      .i_crc_exp (i_crc_exp),
      .i_abort   (i_abort),
      .i_data    (i_data),
      .i_valid   (i_valid),
      .o_ready   (o_ready),
      .o_busy    (o_busy),
      .o_done    (o_done),
      .o_crc     (o_crc),
      .o_err     (o_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // CRC of the whole bit stream (words MSB-first, then WPOLY-1 zeros) by serial division.
   function automatic logic [3:0] msg_crc(input logic [8:0] w [0:255], input int n,
                                          input logic [8:0] last, input logic [4:0] p);
      logic [4:0] r;
      logic [8:0] cur;
      r = '0;
      for (int k = 0; k <= n; k++) begin
         cur = (k == n) ? last : w[k];
         for (int b = 8; b >= 0; b--) begin
            r = {r[3:0], cur[b]};
            if (r[4]) r = r ^ p;
         end
      end
      for (int b = 0; b < 4; b++) begin
         r = {r[3:0], 1'b0};
         if (r[4]) r = r ^ p;
      end
      return r[3:0];
   endfunction

   // Reference model: frame-level bookkeeping, result from the full message.
   bit         m_frame = 1'b0;
   bit         m_done = 1'b0;
   logic [3:0] m_crc = '0;
   logic       m_err = 1'b0;
   int         m_left = 0;
   int         m_nw = 0;
   logic [4:0] m_poly = '0;
   logic       m_mode = 1'b0;
   logic [3:0] m_exp = '0;
   logic [8:0] m_words [0:255];

   always @(posedge clk) begin
      if (i_rst) begin
         m_frame <= 1'b0;
         m_done  <= 1'b0;
         m_crc   <= '0;
         m_err   <= 1'b0;
         m_nw    <= 0;
      end else if (m_done) begin
         m_done <= 1'b0;
      end else if (!m_frame) begin
         if (i_start) begin
            m_poly <= i_poly;
            m_mode <= i_mode;
            m_exp  <= i_crc_exp;
            m_nw   <= 0;
            if (i_len == 0) begin
               m_done <= 1'b1;
               m_crc  <= '0;
               m_err  <= i_mode && (i_crc_exp != 0);
            end else begin
               m_frame <= 1'b1;
               m_left  <= int'(i_len);
            end
         end
      end else if (i_abort) begin
         m_frame <= 1'b0;
      end else if (i_valid) begin
         m_words[m_nw] <= i_data;
         m_nw   <= m_nw + 1;
         m_left <= m_left - 1;
         if (m_left == 1) begin
            m_frame <= 1'b0;
            m_done  <= 1'b1;
            m_crc   <= msg_crc(m_words, m_nw, i_data, m_poly);
            m_err   <= m_mode && (msg_crc(m_words, m_nw, i_data, m_poly) != m_exp);
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("cyc_ready", o_ready, m_frame && !i_abort);
         chk("cyc_busy", o_busy, m_frame);
         chk("cyc_done", o_done, m_done);
         chk("cyc_crc", o_crc, m_crc);
         chk("cyc_err", o_err, m_err);
         if (o_done === 1'b1) done_seen <= done_seen + 1;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame(input logic mode, input logic [7:0] len, input logic [3:0] cexp);
      i_start   = 1'b1;
      i_mode    = mode;
      i_len     = len;
      i_crc_exp = cexp;
      tick();
      i_start = 1'b0;
   endtask

   task automatic send_word(input logic [8:0] w, input int gap);
      i_valid = 1'b0;
      repeat (gap) tick();
      i_data  = w;
      i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
   endtask

   task automatic wait_done(input string name, input logic [3:0] exp_crc, input logic exp_err);
      int n;
      n = 0;
      @(negedge clk);
      while (o_done !== 1'b1 && n < 20) begin
         n++;
         @(negedge clk);
      end
      chk({name, "_latency"}, n, 0);
      chk({name, "_crc"}, o_crc, exp_crc);
      chk({name, "_err"}, o_err, exp_err);
      $display("frame %s: crc=%h err=%b after %0d extra cycles", name, o_crc, o_err, n);
      tick();
   endtask

   initial begin
      logic [8:0] pw [0:255];
      int d0;
      for (int k = 0; k < 256; k++) pw[k] = '0;
      chk("model_pin_001", msg_crc(pw, 0, 9'h001, POLY), 4'h3);
      chk("model_pin_100", msg_crc(pw, 0, 9'h100, POLY), 4'hF);
      pw[0] = 9'h001;
      chk("model_pin_2w", msg_crc(pw, 1, 9'h000, POLY), 4'hD);

      repeat (2) @(posedge clk);
      #1;
      cmp_en = 1'b1;
      @(negedge clk);
      chk("reset_busy", o_busy, 0);
      chk("reset_crc", o_crc, 0);
      tick();
      i_rst = 1'b0;
      tick();

      start_frame(1'b0, 8'd1, 4'h0);
      send_word(9'h001, 0);
      wait_done("t1_gen_001", 4'h3, 1'b0);

      start_frame(1'b0, 8'd1, 4'h0);
      send_word(9'h100, 0);
      wait_done("t2_gen_100", 4'hF, 1'b0);

      d0 = done_seen;
      start_frame(1'b0, 8'd2, 4'h0);
      send_word(9'h001, 0);
      i_poly = 5'b11001;
      i_mode = 1'b1;
      i_len  = 8'd7;
      send_word(9'h000, 3);
      wait_done("t3_stall", 4'hD, 1'b0);
      chk("t3_done_once", done_seen - d0, 1);
      i_poly = POLY;

      start_frame(1'b1, 8'd1, 4'h3);
      send_word(9'h001, 0);
      wait_done("t4_chk_ok", 4'h3, 1'b0);
      start_frame(1'b1, 8'd1, 4'h2);
      send_word(9'h001, 0);
      wait_done("t4_chk_bad", 4'h3, 1'b1);

      d0 = done_seen;
      start_frame(1'b0, 8'd3, 4'h0);
      send_word(9'h100, 0);
      i_abort = 1'b1;
      i_valid = 1'b1;
      i_data  = 9'h055;
      @(negedge clk);
      chk("t5_ready_in_abort", o_ready, 0);
      tick();
      i_abort = 1'b0;
      i_valid = 1'b0;
      @(negedge clk);
      chk("t5_idle_after_abort", o_busy, 0);
      chk("t5_crc_held", o_crc, 4'h3);
      chk("t5_err_held", o_err, 1);
      repeat (3) tick();
      chk("t5_no_done", done_seen - d0, 0);

      start_frame(1'b0, 8'd3, 4'h0);
      send_word(9'h001, 0);
      i_rst = 1'b1;
      tick();
      chk("t5_rst_busy", o_busy, 0);
      chk("t5_rst_ready", o_ready, 0);
      chk("t5_rst_done", o_done, 0);
      chk("t5_rst_crc", o_crc, 0);
      chk("t5_rst_err", o_err, 0);
      i_rst = 1'b0;
      tick();

      d0 = done_seen;
      start_frame(1'b0, 8'd2, 4'h0);
      send_word(9'h001, 0);
      i_start   = 1'b1;
      i_len     = 8'd1;
      i_mode    = 1'b1;
      i_crc_exp = 4'h0;
      tick();
      i_start = 1'b0;
      i_mode  = 1'b0;
      send_word(9'h000, 0);
      wait_done("t6_start_in_run", 4'hD, 1'b0);
      chk("t6_done_once", done_seen - d0, 1);

      start_frame(1'b1, 8'd0, 4'h5);
      wait_done("t6_len0", 4'h0, 1'b1);

      repeat (2) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation timed out");
   end

endmodule
